// File: rtl/usbf_csr_seq_if.sv
// rtl/usbf_csr_seq_if.sv - bus-side request/ready/data bundle for the USB CSR sequencer
interface usbf_csr_seq_if;
  logic        wt_en_i;
  logic        rd_en_i;
  logic        enable_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        wt_ready_o;
  logic        rd_ready_o;

  modport master (
    output wt_en_i, rd_en_i, enable_i, addr_i, wdata_i,
    input  rdata_o, wt_ready_o, rd_ready_o
  );

  modport slave (
    input  wt_en_i, rd_en_i, enable_i, addr_i, wdata_i,
    output rdata_o, wt_ready_o, rd_ready_o
  );
endinterface

// File: rtl/usbf_csr_seq.sv
// rtl/usbf_csr_seq.sv - sequences bus accesses onto the USB register file or endpoint FIFOs
module usbf_csr_seq #(
  parameter int         TIMEOUT   = 255,
  parameter logic [3:0] FIFO_PAGE = 4'hF
) (
  input  logic              hclk_i,
  input  logic              hrst_i,
  usbf_csr_seq_if.slave     bus,
  output logic              reg_we_o,
  output logic              reg_re_o,
  output logic [11:0]       reg_addr_o,
  output logic [31:0]       reg_wdata_o,
  input  logic [31:0]       reg_rdata_i,
  output logic              fifo_req_o,
  output logic              fifo_wr_o,
  output logic [3:0]        fifo_ep_o,
  output logic [31:0]       fifo_wdata_o,
  input  logic              fifo_ack_i,
  input  logic [31:0]       fifo_rdata_i,
  output logic [1:0]        err_o,
  input  logic              err_clr_i,
  output logic              busy_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REG   = 3'd1;
  localparam logic [2:0] S_RDCAP = 3'd2;
  localparam logic [2:0] S_FIFO  = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  localparam logic [7:0]  TO_LAST  = 8'(TIMEOUT - 1);
  localparam logic [31:0] TO_RDATA = 32'hDEAD_BEEF;

  logic [2:0]  state, state_nxt;
  logic        pend;
  logic        en_q;
  logic [7:0]  cnt;
  logic [31:0] rdata_q;
  logic        wt_rdy_q, rd_rdy_q;

  logic req_any, accept, overlap, acc_wr, acc_en, acc_fifo, fifo_done, fifo_tmo;

  assign bus.rdata_o    = rdata_q;
  assign bus.wt_ready_o = wt_rdy_q;
  assign bus.rd_ready_o = rd_rdy_q;

  // Acceptance decode and next-state selection; a pending read reuses the latched address and enable
  always_comb begin
    req_any   = bus.wt_en_i | bus.rd_en_i;
    accept    = (state == S_IDLE) && (req_any || pend);
    overlap   = req_any && ((state != S_IDLE) || pend);
    acc_wr    = !pend && bus.wt_en_i;
    acc_en    = pend ? en_q : bus.enable_i;
    acc_fifo  = pend ? (reg_addr_o[11:8] == FIFO_PAGE) : (bus.addr_i[11:8] == FIFO_PAGE);
    fifo_done = (state == S_FIFO) && fifo_ack_i;
    fifo_tmo  = (state == S_FIFO) && !fifo_ack_i && (cnt == TO_LAST);
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = !acc_en ? S_RESP : (acc_fifo ? S_FIFO : S_REG);
      S_REG:   state_nxt = fifo_wr_o ? S_IDLE : S_RDCAP;
      S_RDCAP: state_nxt = S_IDLE;
      S_FIFO:  if (fifo_done || fifo_tmo) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, strobes, ready pulses, captured data and sticky errors, all registered
  always_ff @(posedge hclk_i) begin
    if (hrst_i) begin
      state        <= S_IDLE;
      busy_o       <= 1'b0;
      pend         <= 1'b0;
      en_q         <= 1'b0;
      cnt          <= 8'd0;
      rdata_q      <= 32'd0;
      wt_rdy_q     <= 1'b0;
      rd_rdy_q     <= 1'b0;
      reg_we_o     <= 1'b0;
      reg_re_o     <= 1'b0;
      reg_addr_o   <= 12'd0;
      reg_wdata_o  <= 32'd0;
      fifo_req_o   <= 1'b0;
      fifo_wr_o    <= 1'b0;
      fifo_ep_o    <= 4'd0;
      fifo_wdata_o <= 32'd0;
      err_o        <= 2'b00;
    end else begin
      state    <= state_nxt;
      busy_o   <= (state_nxt != S_IDLE);
      reg_we_o <= 1'b0;
      reg_re_o <= 1'b0;
      wt_rdy_q <= 1'b0;
      rd_rdy_q <= 1'b0;
      err_o    <= (err_clr_i ? 2'b00 : err_o) | {overlap, fifo_tmo};

      if (accept) begin
        fifo_wr_o <= acc_wr;
        pend      <= !pend && bus.wt_en_i && bus.rd_en_i;
        if (!pend) begin
          reg_addr_o   <= bus.addr_i[11:0];
          reg_wdata_o  <= bus.wdata_i;
          fifo_ep_o    <= bus.addr_i[5:2];
          fifo_wdata_o <= bus.wdata_i;
          en_q         <= bus.enable_i;
        end
        if (!acc_en) begin
          // Disabled address space: answer immediately so the bus never stalls
          wt_rdy_q <= acc_wr;
          rd_rdy_q <= !acc_wr;
          if (!acc_wr) rdata_q <= 32'd0;
        end else if (!acc_fifo) begin
          reg_we_o <= acc_wr;
          wt_rdy_q <= acc_wr;
          reg_re_o <= !acc_wr;
        end else begin
          fifo_req_o <= 1'b1;
          cnt        <= 8'd0;
        end
      end

      if (state == S_REG && !fifo_wr_o) begin
        rdata_q  <= reg_rdata_i;
        rd_rdy_q <= 1'b1;
      end

      if (fifo_done || fifo_tmo) begin
        fifo_req_o <= 1'b0;
        wt_rdy_q   <= fifo_wr_o;
        rd_rdy_q   <= !fifo_wr_o;
        if (!fifo_wr_o) rdata_q <= fifo_done ? fifo_rdata_i : TO_RDATA;
      end else if (state == S_FIFO) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_usbf_csr_seq.sv
// tb/tb_usbf_csr_seq.sv - directed table-driven bench for usbf_csr_seq
module tb_usbf_csr_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_we, reg_re;
  logic [11:0] reg_addr;
  logic [31:0] reg_wdata, reg_rdata;
  logic        fifo_req, fifo_wr;
  logic [3:0]  fifo_ep;
  logic [31:0] fifo_wdata, fifo_rdata;
  logic        fifo_ack;
  logic [1:0]  err;
  logic        err_clr;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  usbf_csr_seq_if bus ();

  usbf_csr_seq #(.TIMEOUT(8), .FIFO_PAGE(4'hF)) dut (
    .hclk_i       (clk),
    .hrst_i       (rst),
    .bus          (bus),
    .reg_we_o     (reg_we),
    .reg_re_o     (reg_re),
    .reg_addr_o   (reg_addr),
    .reg_wdata_o  (reg_wdata),
    .reg_rdata_i  (reg_rdata),
    .fifo_req_o   (fifo_req),
    .fifo_wr_o    (fifo_wr),
    .fifo_ep_o    (fifo_ep),
    .fifo_wdata_o (fifo_wdata),
    .fifo_ack_i   (fifo_ack),
    .fifo_rdata_i (fifo_rdata),
    .err_o        (err),
    .err_clr_i    (err_clr),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic        en;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] reg_rdata;
    int          ack_k;
    logic [31:0] fifo_rdata;
    int          clr_k;
    int          exp_ready_k;
    logic        exp_rd;
    logic [31:0] exp_rdata;
    int          exp_we;
    int          exp_re;
    int          exp_req;
    logic [1:0]  exp_err;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_bus();
    bus.wt_en_i  = 1'b0;
    bus.rd_en_i  = 1'b0;
    bus.enable_i = 1'b1;
    bus.addr_i   = 32'hFFFF_FFFF;
    bus.wdata_i  = 32'h0;
  endtask

  task automatic clear_err(input string name);
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    check({name, " err_cleared"}, 32'(err), 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int rdy_k, rdy_n, idle_k, we_n, re_n, req_n, hold_bad, both, strobe1;
    logic rd_seen;
    logic [31:0] rdat;
    string p;
    p = $sformatf("v%0d", idx);
    rdy_k = 0; rdy_n = 0; idle_k = 0; we_n = 0; re_n = 0; req_n = 0;
    hold_bad = 0; both = 0; strobe1 = 0; rd_seen = 1'b0; rdat = 32'h0;
    @(posedge clk); #1;
    bus.wt_en_i  = v.wr;
    bus.rd_en_i  = !v.wr;
    bus.enable_i = v.en;
    bus.addr_i   = v.addr;
    bus.wdata_i  = v.wdata;
    reg_rdata    = v.reg_rdata;
    fifo_rdata   = v.fifo_rdata;
    @(posedge clk); #1;
    idle_bus();
    for (int k = 1; k <= 14; k++) begin
      fifo_ack = (k == v.ack_k);
      err_clr  = (k == v.clr_k);
      @(negedge clk);
      if (bus.wt_ready_o || bus.rd_ready_o) begin
        rdy_n++;
        if (rdy_k == 0) begin
          rdy_k   = k;
          rd_seen = bus.rd_ready_o;
          rdat    = bus.rdata_o;
        end
      end
      if (bus.wt_ready_o && bus.rd_ready_o) both++;
      if (reg_we) we_n++;
      if (reg_re) re_n++;
      if (fifo_req) req_n++;
      if (!busy && idle_k == 0) idle_k = k;
      if (busy && (reg_addr !== v.addr[11:0] || reg_wdata !== v.wdata)) hold_bad++;
      if (k == 1) begin
        strobe1 = int'(reg_we) + int'(reg_re);
        if (v.exp_req > 0) begin
          check({p, " fifo_ep"}, 32'(fifo_ep), 32'(v.addr[5:2]));
          check({p, " fifo_wr"}, 32'(fifo_wr), 32'(v.wr));
          check({p, " fifo_wdata"}, fifo_wdata, v.wdata);
        end
      end
      @(posedge clk); #1;
    end
    fifo_ack = 1'b0;
    err_clr  = 1'b0;
    check({p, " ready_cycle"}, 32'(rdy_k), 32'(v.exp_ready_k));
    check({p, " ready_count"}, 32'(rdy_n), 32'd1);
    check({p, " ready_kind"}, 32'(rd_seen), 32'(v.exp_rd));
    if (v.exp_rd) check({p, " rdata"}, rdat, v.exp_rdata);
    check({p, " we_count"}, 32'(we_n), 32'(v.exp_we));
    check({p, " re_count"}, 32'(re_n), 32'(v.exp_re));
    check({p, " strobe_at_t1"}, 32'(strobe1), 32'(v.exp_we + v.exp_re));
    check({p, " req_cycles"}, 32'(req_n), 32'(v.exp_req));
    check({p, " idle_cycle"}, 32'(idle_k), 32'(v.exp_ready_k + 1));
    check({p, " addr_hold"}, 32'(hold_bad), 32'd0);
    check({p, " ready_overlap"}, 32'(both), 32'd0);
    @(negedge clk);
    check({p, " err"}, 32'(err), 32'(v.exp_err));
    clear_err(p);
  endtask

  initial begin
    int wt_n, rd_n, wt_k, rd_k, re_k, both, rdy_n;
    logic [31:0] rdat, re_addr;

    //           wr    en    addr          wdata         reg_rdata     ack fifo_rdata    clr rdy rd    exp_rdata     we re req err
    vecs[0] = '{1'b1, 1'b1, 32'h0000_0010, 32'h1234_5678, 32'h0,        0, 32'h0,        0, 1, 1'b0, 32'h0,        1, 0, 0, 2'b00};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_0020, 32'h0,         32'hA5A5_0001, 0, 32'h0,       0, 2, 1'b1, 32'hA5A5_0001, 0, 1, 0, 2'b00};
    vecs[2] = '{1'b0, 1'b1, 32'h0000_0F0C, 32'h0,         32'h0,        4, 32'h0BAD_F00D, 0, 5, 1'b1, 32'h0BAD_F00D, 0, 0, 4, 2'b00};
    vecs[3] = '{1'b1, 1'b1, 32'h0000_0F14, 32'hCAFE_0001, 32'h0,        2, 32'h0,        0, 3, 1'b0, 32'h0,        0, 0, 2, 2'b00};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_0030, 32'h0,         32'h7777_7777, 0, 32'h0,       0, 1, 1'b1, 32'h0,        0, 0, 0, 2'b00};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_0F00, 32'h0000_0042, 32'h0,        0, 32'h0,        0, 1, 1'b0, 32'h0,        0, 0, 0, 2'b00};
    vecs[6] = '{1'b0, 1'b1, 32'h0000_0F20, 32'h0,         32'h0,        0, 32'h1357_9BDF, 0, 9, 1'b1, 32'hDEAD_BEEF, 0, 0, 8, 2'b01};
    vecs[7] = '{1'b0, 1'b1, 32'h0000_0F24, 32'h0,         32'h0,        8, 32'h5555_AAAA, 0, 9, 1'b1, 32'h5555_AAAA, 0, 0, 8, 2'b00};
    vecs[8] = '{1'b1, 1'b1, 32'h0000_0F28, 32'h0000_0099, 32'h0,        0, 32'h0,        8, 9, 1'b0, 32'h0,        0, 0, 8, 2'b01};

    rst = 1'b1; err_clr = 1'b0; fifo_ack = 1'b0; fifo_rdata = 32'h0; reg_rdata = 32'h0;
    idle_bus();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset ready", 32'({bus.wt_ready_o, bus.rd_ready_o}), 32'd0);
    check("reset rdata", bus.rdata_o, 32'd0);
    check("reset strobes", 32'({reg_we, reg_re, fifo_req}), 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset reg_addr", 32'(reg_addr), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Simultaneous write+read, plus a third request while busy
    wt_n = 0; rd_n = 0; wt_k = 0; rd_k = 0; re_k = 0; both = 0; rdat = 32'h0; re_addr = 32'h0;
    @(posedge clk); #1;
    bus.wt_en_i = 1'b1; bus.rd_en_i = 1'b1; bus.enable_i = 1'b1;
    bus.addr_i = 32'h0000_0040; bus.wdata_i = 32'h0000_0011; reg_rdata = 32'h2222_3333;
    @(posedge clk); #1;
    bus.wt_en_i = 1'b0; bus.rd_en_i = 1'b1; bus.addr_i = 32'h0000_0999;
    for (int k = 1; k <= 10; k++) begin
      if (k == 2) bus.rd_en_i = 1'b0;
      @(negedge clk);
      if (bus.wt_ready_o) begin wt_n++; if (wt_k == 0) wt_k = k; end
      if (bus.rd_ready_o) begin rd_n++; if (rd_k == 0) begin rd_k = k; rdat = bus.rdata_o; end end
      if (bus.wt_ready_o && bus.rd_ready_o) both++;
      if (reg_re && re_k == 0) begin re_k = k; re_addr = 32'(reg_addr); end
      @(posedge clk); #1;
    end
    idle_bus();
    check("sim wt_count", 32'(wt_n), 32'd1);
    check("sim rd_count", 32'(rd_n), 32'd1);
    check("sim wt_cycle", 32'(wt_k), 32'd1);
    check("sim re_cycle", 32'(re_k), 32'd3);
    check("sim re_addr", re_addr, 32'h0000_0040);
    check("sim rd_cycle", 32'(rd_k), 32'd4);
    check("sim rdata", rdat, 32'h2222_3333);
    check("sim ready_overlap", 32'(both), 32'd0);
    @(negedge clk);
    check("sim err", 32'(err), 32'b10);
    clear_err("sim");

    // Reset during a FIFO write aborts it without a ready pulse
    rdy_n = 0;
    @(posedge clk); #1;
    bus.wt_en_i = 1'b1; bus.addr_i = 32'h0000_0F08; bus.wdata_i = 32'h0000_00AB;
    @(posedge clk); #1;
    idle_bus();
    for (int k = 1; k <= 8; k++) begin
      rst = (k == 2);
      @(negedge clk);
      if (bus.wt_ready_o || bus.rd_ready_o) rdy_n++;
      if (k == 1) check("rst fifo_req_before", 32'(fifo_req), 32'd1);
      if (k == 3) begin
        check("rst fifo_req_after", 32'(fifo_req), 32'd0);
        check("rst busy_after", 32'(busy), 32'd0);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    check("rst no_ready", 32'(rdy_n), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/usbf_csr_seq.md
USBF_CSR_SEQ -- requirements
Module: usbf_csr_seq

Interface
REQ-001 Parameter TIMEOUT, default 255: FIFO wait limit in cycles; 1..255, 8-bit counter.
REQ-002 Parameter FIFO_PAGE, default 4'hF: value of addr_i[11:8] that selects the FIFO data window.
REQ-003 Clocking: one clock. Reset is synchronous and active-high.
- hclk_i  in  1: clock.
- hrst_i  in  1: sync reset, active-high.
REQ-004 Bus-interface side ports:
- wt_en_i  in  1: write request pulse.
- rd_en_i  in  1: read request pulse.
- enable_i  in  1: USB address space selected.
- addr_i  in  32: access address.
- wdata_i  in  32: write data.
- rdata_o  out  32: read data.
- wt_ready_o  out  1: write done pulse.
- rd_ready_o  out  1: read done pulse.
REQ-005 Register-file side ports:
- reg_we_o  out  1: register write strobe.
- reg_re_o  out  1: register read strobe.
- reg_addr_o  out  12: register address.
- reg_wdata_o  out  32: register write data.
- reg_rdata_i  in  32: register read data, combinational from reg_addr_o.
REQ-006 FIFO side ports (in hclk_i domain after synchronisation):
- fifo_req_o  out  1: FIFO access request level.
- fifo_wr_o  out  1: 1 = push, 0 = pop.
- fifo_ep_o  out  4: endpoint, taken from addr_i[5:2].
- fifo_wdata_o  out  32: push data.
- fifo_ack_i  in  1: access-complete pulse.
- fifo_rdata_i  in  32: pop data, valid with fifo_ack_i.
REQ-007 Status ports:
- err_o  out  2: sticky errors; [0] = timeout, [1] = overlap.
- err_clr_i  in  1: clears err_o.
- busy_o  out  1: state != IDLE.

Function
REQ-008 States are IDLE, REG, RDCAP, FIFO, RESP; reset state is IDLE.
REQ-009 Acceptance: an access is accepted in IDLE when wt_en_i|rd_en_i is high. Accept cycle = T. addr_i, wdata_i and the direction are latched at T.
REQ-010 Simultaneous wt_en_i and rd_en_i at T: the write is serviced first. The read is latched as pending and accepted automatically in the cycle after the write's ready pulse.
REQ-011 Request while not IDLE (other than the pending case): the request is dropped and err_o[1] is set. No strobes, no ready.
REQ-012 enable_i low at T: no strobes are issued. The matching ready pulses at T+1 with rdata_o = 0 (keeps the bus from stalling).
REQ-013 Register write (addr[11:8] != FIFO_PAGE): REG at T+1 with reg_we_o = 1 for exactly one cycle and wt_ready_o = 1 in the same cycle. Return to IDLE at T+2.
REQ-014 Register read:
- T+1: reg_re_o = 1 for one cycle; reg_rdata_i is captured into rdata_o.
- T+2: RDCAP, rd_ready_o = 1 for one cycle.
- Back to IDLE after that.
REQ-015 reg_addr_o = latched addr[11:0] and reg_wdata_o = latched wdata. Both are held stable while not IDLE.
REQ-016 FIFO access: from T+1, fifo_req_o = 1 while in FIFO. fifo_wr_o, fifo_ep_o and fifo_wdata_o are held stable throughout.
REQ-017 fifo_ack_i high in FIFO at cycle A:
- A+1: fifo_req_o = 0.
- For a pop, rdata_o captures fifo_rdata_i at A.
- A+1: RESP, with the matching ready pulsing for one cycle.
- A+2: IDLE.
REQ-018 Timeout: an 8-bit counter clears on entry to FIFO and increments each FIFO cycle.
- At count == TIMEOUT-1 with no ack: go to RESP, drop fifo_req_o, set err_o[0].
- The ready still pulses. rdata_o = 32'hDEAD_BEEF for reads.
REQ-019 Ack on the same cycle as timeout: the ack wins; no error is set.
REQ-020 fifo_ack_i outside FIFO is ignored.
REQ-021 Ready pulses:
- wt_ready_o and rd_ready_o are never high together.
- Each accepted access produces exactly one pulse.
REQ-022 rdata_o holds its last captured value until the next read capture.
REQ-023 err_o bits set independently.
- err_clr_i clears both bits next cycle.
- Set and clear in the same cycle: set wins.
REQ-024 All outputs are registered, except reg_rdata_i, which is only captured.

Reset
REQ-025 While hrst_i is high at a clock edge, the following are 0 and the state is IDLE:
- all outputs,
- the pending read,
- the timeout counter.
REQ-026 Reset mid-operation (any state): takes effect next edge. fifo_req_o drops and no ready pulse is issued for the aborted access.

Verification
REQ-027 Register write: write addr 0x010, wdata 0x1234_5678 at T -> reg_we_o at T+1 with reg_addr_o = 0x010; wt_ready_o at T+1; IDLE at T+2.
REQ-028 Register read: read addr 0x020, reg_rdata_i = 0xA5A5_0001 -> reg_re_o at T+1; rd_ready_o at T+2 with rdata_o = 0xA5A5_0001.
REQ-029 FIFO pop: read addr 0xF0C, ack at T+4 with fifo_rdata_i = 0x0BAD_F00D -> fifo_ep_o = 3 and req high T+1..T+4; rd_ready_o at T+5 with rdata_o = 0x0BAD_F00D.
REQ-030 Timeout: TIMEOUT = 8, FIFO write with no ack -> req high for 8 cycles; wt_ready_o next cycle; err_o = 2'b01; err_clr_i -> 2'b00.
REQ-031 Simultaneous requests: wt_en_i and rd_en_i together -> write completes, then the read completes. A third request while busy sets err_o[1]; exactly two ready pulses total.
REQ-032 Reset mid-FIFO: hrst_i at T+2 of a FIFO access -> fifo_req_o = 0, busy_o = 0 next cycle, no ready pulse.
